// File: rtl/channel_seq_ctrl.sv
// PAM-4 symbol sequencer for a channel model: clears the channel, maps one frame of
// symbols to signed levels, flushes the pulse-response tail with zeros, then counts the frame.
module channel_seq_ctrl #(
  parameter int SIGNAL_RESOLUTION     = 8,
  parameter int SYMBOL_SEPERATION     = 56,
  parameter int PULSE_RESPONSE_LENGTH = 2,
  parameter int FRAME_LEN             = 16
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                start,
  input  logic                                abort,
  input  logic [1:0]                          sym_in,
  input  logic                                sym_in_valid,
  output logic                                sym_in_ready,
  output logic                                chan_rstn,
  output logic signed [SIGNAL_RESOLUTION-1:0] chan_signal_in,
  output logic                                chan_signal_in_valid,
  output logic                                busy,
  output logic                                frame_done,
  output logic [15:0]                         frame_count
);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, FLUSH, DONE} state_t;

  localparam logic [15:0] FRAME_LEN_W = 16'(FRAME_LEN);
  localparam logic [15:0] LAST_SYM    = 16'(FRAME_LEN - 1);
  localparam bit          HAS_FLUSH   = (PULSE_RESPONSE_LENGTH > 1);
  localparam logic [15:0] LAST_FLUSH  = HAS_FLUSH ? 16'(PULSE_RESPONSE_LENGTH - 2) : 16'd0;

  state_t             state, next_state;
  logic [15:0]        sym_cnt;
  logic [15:0]        flush_cnt;
  logic               accept;
  logic               flush_issue;
  logic signed [31:0] level;

  // Symbol-to-level map done in 32-bit signed so the negative levels stay exact before truncation
  assign level  = ($signed({30'd0, sym_in}) * 32'sd2 - 32'sd3) * SYMBOL_SEPERATION / 32'sd2;
  assign accept = sym_in_valid && sym_in_ready;
  assign busy   = (state != IDLE);

  always_comb begin
    next_state   = state;
    sym_in_ready = 1'b0;
    flush_issue  = 1'b0;
    frame_done   = 1'b0;
    case (state)
      IDLE:  if (start) next_state = CLEAR;
      CLEAR: next_state = RUN;
      RUN: begin
        sym_in_ready = (sym_cnt < FRAME_LEN_W);
        if (sym_in_valid && sym_cnt == LAST_SYM) next_state = FLUSH;
      end
      FLUSH: begin
        flush_issue = HAS_FLUSH;
        if (!HAS_FLUSH || flush_cnt == LAST_FLUSH) next_state = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    // Abort wins over everything, including the ready handshake in the same cycle
    if (abort) begin
      next_state   = IDLE;
      sym_in_ready = 1'b0;
      flush_issue  = 1'b0;
      frame_done   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sym_cnt   <= '0;
      flush_cnt <= '0;
    end else begin
      if (abort || state != RUN) sym_cnt <= '0;
      else if (accept)           sym_cnt <= sym_cnt + 16'd1;
      if (flush_issue) flush_cnt <= flush_cnt + 16'd1;
      else             flush_cnt <= '0;
    end
  end

  // Sample register: an already-registered sample still shows valid for its cycle after an abort
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      chan_signal_in       <= '0;
      chan_signal_in_valid <= 1'b0;
    end else if (accept) begin
      chan_signal_in       <= SIGNAL_RESOLUTION'(level);
      chan_signal_in_valid <= 1'b1;
    end else if (flush_issue) begin
      chan_signal_in       <= '0;
      chan_signal_in_valid <= 1'b1;
    end else begin
      chan_signal_in_valid <= 1'b0;
    end
  end

  // Channel reset is registered from next_state so it is low for exactly the CLEAR cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      chan_rstn   <= 1'b0;
      frame_count <= '0;
    end else begin
      chan_rstn <= (next_state != CLEAR);
      if (frame_done) frame_count <= frame_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_channel_seq_ctrl.sv
// Directed bench for channel_seq_ctrl: table of per-cycle vectors plus hand sequences
// for frame_count wrap and reset asserted during FLUSH.
module tb_channel_seq_ctrl;

  logic              clk;
  logic              rstn;
  logic              start;
  logic              abort;
  logic [1:0]        sym_in;
  logic              sym_in_valid;
  logic              sym_in_ready;
  logic              chan_rstn;
  logic signed [7:0] chan_signal_in;
  logic              chan_signal_in_valid;
  logic              busy;
  logic              frame_done;
  logic [15:0]       frame_count;

  typedef struct {
    logic       start;
    logic       abort;
    logic       valid;
    logic [1:0] sym;
    logic       rdy;
    logic       crn;
    logic       sv;
    int         sig;
    logic       bsy;
    logic       fd;
    int         fc;
  } vec_t;

  vec_t vecs[$];
  int   vectors_applied = 0;
  int   miscompares     = 0;

  channel_seq_ctrl #(
    .SIGNAL_RESOLUTION(8),
    .SYMBOL_SEPERATION(56),
    .PULSE_RESPONSE_LENGTH(2),
    .FRAME_LEN(4)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .start(start),
    .abort(abort),
    .sym_in(sym_in),
    .sym_in_valid(sym_in_valid),
    .sym_in_ready(sym_in_ready),
    .chan_rstn(chan_rstn),
    .chan_signal_in(chan_signal_in),
    .chan_signal_in_valid(chan_signal_in_valid),
    .busy(busy),
    .frame_done(frame_done),
    .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input int act, input int exp);
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add_vec(input logic st, input logic ab, input logic vl, input int sym,
                         input logic rdy, input logic crn, input logic sv, input int sig,
                         input logic bsy, input logic fd, input int fc);
    vec_t v;
    v.start = st; v.abort = ab; v.valid = vl; v.sym = 2'(sym);
    v.rdy = rdy; v.crn = crn; v.sv = sv; v.sig = sig;
    v.bsy = bsy; v.fd = fd; v.fc = fc;
    vecs.push_back(v);
  endtask

  // Drive one cycle's inputs at the negedge, compare just after, then advance one clock
  task automatic apply_stimulus(input vec_t v, input int idx);
    string tag;
    start        = v.start;
    abort        = v.abort;
    sym_in_valid = v.valid;
    sym_in       = v.sym;
    #1;
    tag = $sformatf("v%0d", idx);
    vectors_applied++;
    check_output({tag, " sym_in_ready"}, int'(sym_in_ready), int'(v.rdy));
    check_output({tag, " chan_rstn"}, int'(chan_rstn), int'(v.crn));
    check_output({tag, " sig_valid"}, int'(chan_signal_in_valid), int'(v.sv));
    check_output({tag, " sig"}, int'(chan_signal_in), v.sig);
    check_output({tag, " busy"}, int'(busy), int'(v.bsy));
    check_output({tag, " frame_done"}, int'(frame_done), int'(v.fd));
    check_output({tag, " frame_count"}, int'(frame_count), v.fc);
    step();
  endtask

  task automatic drive(input logic st, input logic vl, input int sym);
    start        = st;
    abort        = 1'b0;
    sym_in_valid = vl;
    sym_in       = 2'(sym);
  endtask

  initial begin
    int done_seen;

    // Full frame 0,1,2,3 back-to-back
    add_vec(1,0,0,0, 0,1,0,  0, 0,0,0);
    add_vec(0,0,1,0, 0,0,0,  0, 1,0,0);
    add_vec(0,0,1,0, 1,1,0,  0, 1,0,0);
    add_vec(0,0,1,1, 1,1,1,-84, 1,0,0);
    add_vec(0,0,1,2, 1,1,1,-28, 1,0,0);
    add_vec(0,0,1,3, 1,1,1, 28, 1,0,0);
    add_vec(0,0,1,0, 0,1,1, 84, 1,0,0);
    add_vec(0,0,0,0, 0,1,1,  0, 1,1,0);
    add_vec(0,0,0,0, 0,1,0,  0, 0,0,1);
    // Gapped input with start pulses in RUN, FLUSH and DONE
    add_vec(1,0,0,0, 0,1,0,  0, 0,0,1);
    add_vec(0,0,0,0, 0,0,0,  0, 1,0,1);
    add_vec(1,0,1,3, 1,1,0,  0, 1,0,1);
    add_vec(0,0,0,0, 1,1,1, 84, 1,0,1);
    add_vec(0,0,1,2, 1,1,0, 84, 1,0,1);
    add_vec(1,0,0,0, 1,1,1, 28, 1,0,1);
    add_vec(0,0,1,1, 1,1,0, 28, 1,0,1);
    add_vec(0,0,0,0, 1,1,1,-28, 1,0,1);
    add_vec(0,0,1,0, 1,1,0,-28, 1,0,1);
    add_vec(1,0,0,0, 0,1,1,-84, 1,0,1);
    add_vec(1,0,0,0, 0,1,1,  0, 1,1,1);
    add_vec(0,0,0,0, 0,1,0,  0, 0,0,2);
    add_vec(0,0,0,0, 0,1,0,  0, 0,0,2);
    // Abort after two symbols, abort beating start, then a full frame
    add_vec(1,0,0,0, 0,1,0,  0, 0,0,2);
    add_vec(0,0,0,0, 0,0,0,  0, 1,0,2);
    add_vec(0,0,1,1, 1,1,0,  0, 1,0,2);
    add_vec(0,0,1,2, 1,1,1,-28, 1,0,2);
    add_vec(0,1,1,3, 0,1,1, 28, 1,0,2);
    add_vec(1,1,0,0, 0,1,0, 28, 0,0,2);
    add_vec(0,0,0,0, 0,1,0, 28, 0,0,2);
    add_vec(1,0,0,0, 0,1,0, 28, 0,0,2);
    add_vec(0,0,0,0, 0,0,0, 28, 1,0,2);
    add_vec(0,0,1,2, 1,1,0, 28, 1,0,2);
    add_vec(0,0,1,2, 1,1,1, 28, 1,0,2);
    add_vec(0,0,1,2, 1,1,1, 28, 1,0,2);
    add_vec(0,0,1,2, 1,1,1, 28, 1,0,2);
    add_vec(0,0,0,0, 0,1,1, 28, 1,0,2);
    add_vec(0,0,0,0, 0,1,1,  0, 1,1,2);
    add_vec(0,0,0,0, 0,1,0,  0, 0,0,3);

    rstn = 1'b0;
    drive(0, 0, 0);
    #1;
    vectors_applied++;
    check_output("reset chan_rstn", int'(chan_rstn), 0);
    check_output("reset sig_valid", int'(chan_signal_in_valid), 0);
    check_output("reset busy", int'(busy), 0);
    check_output("reset frame_count", int'(frame_count), 0);
    step();
    vectors_applied++;
    check_output("reset held chan_rstn", int'(chan_rstn), 0);
    rstn = 1'b1;
    #1;
    vectors_applied++;
    check_output("release chan_rstn", int'(chan_rstn), 0);
    step();

    foreach (vecs[i]) apply_stimulus(vecs[i], i);

    // frame_count wrap from 0xFFFF
    dut.frame_count = 16'hFFFF;
    done_seen = 0;
    drive(1, 0, 0);
    step();
    for (int c = 0; c < 8; c++) begin
      drive(0, 1, c % 4);
      #1;
      if (frame_done) done_seen++;
      step();
    end
    drive(0, 0, 0);
    #1;
    vectors_applied++;
    check_output("wrap frame_done pulses", done_seen, 1);
    check_output("wrap frame_count", int'(frame_count), 0);
    check_output("wrap busy", int'(busy), 0);
    step();

    // Reset asserted while in FLUSH
    drive(1, 0, 0);
    step();
    drive(0, 1, 3);
    step();
    for (int c = 0; c < 4; c++) step();
    #1;
    vectors_applied++;
    check_output("pre-reset flush busy", int'(busy), 1);
    check_output("pre-reset sig", int'(chan_signal_in), 84);
    rstn = 1'b0;
    #1;
    vectors_applied++;
    check_output("flush reset chan_rstn", int'(chan_rstn), 0);
    check_output("flush reset sig_valid", int'(chan_signal_in_valid), 0);
    check_output("flush reset sig", int'(chan_signal_in), 0);
    check_output("flush reset busy", int'(busy), 0);
    check_output("flush reset ready", int'(sym_in_ready), 0);
    check_output("flush reset frame_done", int'(frame_done), 0);
    check_output("flush reset frame_count", int'(frame_count), 0);
    drive(0, 0, 0);
    @(negedge clk);
    rstn = 1'b1;
    step();
    #1;
    vectors_applied++;
    check_output("post-release busy", int'(busy), 0);
    check_output("post-release chan_rstn", int'(chan_rstn), 1);
    check_output("post-release sig_valid", int'(chan_signal_in_valid), 0);
    check_output("post-release frame_count", int'(frame_count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
